argmax_8_16: RTL and testbench
==============================

Name: argmax_8_16

Overview:
- Downstream stage of the fc layer (M=8 outputs, T=16 bits). Consumes the fc output stream of signed T-bit values, grouped into vectors of M consecutive values.
- Emits one result per vector: the index of the maximum value (classification decision) plus the maximum value itself.
- Valid/ready handshake on both sides, same protocol as the fc layer. Input side connects directly to fc output_valid/output_ready/output_data.

Parameters:
- M, 8, number of values per vector (fc output count); M >= 2.
- T, 16, data width in bits; values are two's-complement signed.

Ports:
- clk  input  1  clock; all state updates on posedge clk.
- reset  input  1  synchronous, active-low reset: state clears on a posedge clk where reset==0.
- input_valid  input  1  upstream data valid.
- input_ready  output  1  block accepts input_data this cycle.
- input_data  input  T  signed value, element k of the current vector.
- output_valid  output  1  result register holds a valid result.
- output_ready  input  1  downstream accepts the result this cycle.
- output_data  output  $clog2(M)  index (0..M-1) of the maximum element.
- output_max  output  T  signed maximum value of the vector.

Behaviour:
- Transfer rules:
  - Input transfer occurs on a posedge where input_valid && input_ready.
  - Output transfer occurs on a posedge where output_valid && output_ready.
- Accumulator state: cnt (0..M-1, element position), best_val (T signed), best_idx.
- Result register: output_valid, output_data, output_max.
- Reset (reset==0 at posedge): cnt=0, best_val=0, best_idx=0, output_valid=0, output_data=0, output_max=0. While reset==0, input_ready=0.
  - Reset mid-vector discards the partial vector. Reset with output_valid=1 drops the pending result.
- Comparison on each input transfer with value v at position cnt:
  - cnt==0: candidate = (v, 0) unconditionally.
  - cnt>0: candidate = (v, cnt) if v > best_val (signed, strict), else (best_val, best_idx).
  - Ties keep the lowest index.
- Counter and accumulator update on an input transfer:
  - If cnt<M-1: best <= candidate, cnt <= cnt+1.
  - If cnt==M-1: result register <= candidate, output_valid <= 1, cnt <= 0.
- Latency: result visible on output_valid in the cycle after the M-th element transfer.
- input_ready (combinational, reset==1): = !(cnt==M-1 && output_valid && !output_ready).
  - Stalls only the last element of a vector while the previous result is still pending.
  - Depends combinationally on output_ready, but there is no path from input_valid to input_ready.
- Output register:
  - If an output transfer occurs with no new load, output_valid <= 0.
  - If an output transfer and a new load (last element) occur in the same cycle, the new result loads and output_valid stays 1. This gives full throughput of 1 vector per M cycles.
  - output_data and output_max hold stable while output_valid && !output_ready.
- Arithmetic: only signed T-bit compares; no arithmetic growth. Index width is $clog2(M).
- Throughput: 1 element/cycle sustained when downstream is always ready.

Decomposition:
- Shared package (fc_pkg), reused by the fc layer and this block:
  - data_t typedef (logic signed [T-1:0]).
  - Localparam-style function idx_w(M) = $clog2(M).
- No sub-module. Single module: one always_ff for accumulator, one for result register, combinational candidate and input_ready logic.

Test Plan:
1. Single vector {3,-1,7,2,7,0,-5,1}, both sides always ready -> output_data=2, output_max=7 (tie at index 4 ignored), output_valid=1 exactly 1 cycle after the 8th transfer.
2. All-negative vector {-8,-3,-3,-9,-100,-4,-32768,-7} -> output_data=1, output_max=-3. Max at last position, vector {0,...,0,32767} -> index 7, 32767.
3. output_ready=0 held for 20 cycles with a result pending, next vector streamed -> first 7 elements accepted, input_ready=0 on the 8th until output_ready=1. Both results correct, in order, none lost.
4. Back-to-back 100 random vectors, input_valid and output_ready randomized per cycle (as in the fc bench) -> all indices/values match the golden model, 0 errors.
5. reset=0 asserted after 5 elements of a vector, then released and a fresh vector {1,2,3,4,5,6,7,8} sent -> output_valid=0 during reset, single result index 7, value 8. The partial vector produces no output.
6. Simultaneous output transfer and 8th-element load -> output_valid stays 1 and the new result appears next cycle, no bubble.

Source files
------------

// File: rtl/argmax_8_16_pkg.sv
// Purpose : shared types for the fc output stream and its argmax stage (M=8 values, T=16 bits).
// Latency : n/a (types, constants and a width helper only).
// Backpressure: n/a.
// Contents: data_t (signed T-bit element), idx_t (element index), result_t (index + value pair).
package argmax_8_16_pkg;

  localparam int M = 8;   // values per vector (fc output count), must be >= 2
  localparam int T = 16;  // element width, two's complement

  // Index width for a vector of m elements.
  function automatic int idx_w(input int m);
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

  localparam int IW = idx_w(M);

  typedef logic signed [T-1:0] data_t;
  typedef logic [IW-1:0]       idx_t;

  // Winning element so far: position within the vector and its value.
  typedef struct packed {
    idx_t  idx;
    data_t val;
  } result_t;

  localparam idx_t LAST_IDX = idx_t'(M - 1);

endpackage

// File: rtl/argmax_8_16_if.sv
// Purpose : bundles the argmax input stream (fc output side) and result stream.
// Latency : n/a (wires only).
// Backpressure: valid/ready on both streams; slave = argmax block, master = its environment.
// Signals : input_valid/input_ready/input_data (element stream),
//           output_valid/output_ready/output_data/output_max (result stream).
interface argmax_8_16_if;
  import argmax_8_16_pkg::*;

  logic  input_valid;
  logic  input_ready;
  data_t input_data;

  logic  output_valid;
  logic  output_ready;
  idx_t  output_data;
  data_t output_max;

  // View of the argmax block itself.
  modport slave (
    input  input_valid,
    input  input_data,
    input  output_ready,
    output input_ready,
    output output_valid,
    output output_data,
    output output_max
  );

  // View of the surrounding logic: feeds elements, consumes results.
  modport master (
    output input_valid,
    output input_data,
    output output_ready,
    input  input_ready,
    input  output_valid,
    input  output_data,
    input  output_max
  );

endinterface

// File: rtl/argmax_8_16.sv
// Purpose : per vector of M signed values, reports the index and value of the maximum (lowest index wins ties).
// Latency : result valid in the cycle after the M-th element transfer; 1 element/cycle sustained.
// Backpressure: only the last element of a vector stalls, and only while the previous result is unaccepted.
// Ports   : clk, reset (sync, active-low); bus (slave modport) carries both valid/ready streams.
module argmax_8_16
  import argmax_8_16_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  argmax_8_16_if.slave bus
);

  // Accumulator for the vector in flight.
  idx_t    cnt;
  data_t   best_val;
  idx_t    best_idx;

  // Result register.
  result_t res_q;
  logic    res_vld;

  // Combinational helpers.
  result_t cand;
  logic    last;
  logic    in_rdy;
  logic    in_xfer;
  logic    out_xfer;

  always_comb begin
    last = (cnt == LAST_IDX);

    // Element 0 always seeds the search; afterwards only a strictly larger
    // value replaces the incumbent, so ties keep the lowest index.
    cand = '{idx: best_idx, val: best_val};
    if (cnt == '0) begin
      cand = '{idx: '0, val: bus.input_data};
    end else if (bus.input_data > best_val) begin
      cand = '{idx: cnt, val: bus.input_data};
    end

    // Only the final element needs the result register, and it may load in
    // the same cycle the pending result leaves. No dependence on input_valid.
    in_rdy   = reset && !(last && res_vld && !bus.output_ready);
    in_xfer  = bus.input_valid && in_rdy;
    out_xfer = res_vld && bus.output_ready;
  end

  // Accumulator: position counter and running best.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt      <= '0;
      best_val <= '0;
      best_idx <= '0;
    end else if (in_xfer) begin
      if (last) begin
        // The winner goes straight to the result register; best is left
        // as-is since the next element 0 overrides it unconditionally.
        cnt <= '0;
      end else begin
        cnt      <= cnt + 1'b1;
        best_val <= cand.val;
        best_idx <= cand.idx;
      end
    end
  end

  // Result register: a new load wins over an outgoing transfer, which keeps
  // output_valid high across back-to-back results with no bubble.
  always_ff @(posedge clk) begin
    if (!reset) begin
      res_q   <= '0;
      res_vld <= 1'b0;
    end else if (in_xfer && last) begin
      res_q   <= cand;
      res_vld <= 1'b1;
    end else if (out_xfer) begin
      res_vld <= 1'b0;
    end
  end

  assign bus.input_ready  = in_rdy;
  assign bus.output_valid = res_vld;
  assign bus.output_data  = res_q.idx;
  assign bus.output_max   = res_q.val;

endmodule

// File: tb/tb_argmax_8_16.sv
// Purpose : scoreboard bench for argmax_8_16; expected results queued at stimulus time, checked at output.
// Latency : checks result one cycle after the last element and zero-bubble reload.
// Backpressure: drives held-low, always-high and random output_ready; random input_valid.
module tb_argmax_8_16;
  import argmax_8_16_pkg::*;

  typedef struct {
    int idx;
    int val;
  } exp_t;

  logic clk;
  logic reset;
  int   rdy_mode;   // 0: output_ready=1, 1: random, 2: output_ready=0
  int   n_tests;
  int   n_fail;
  int   n_out;
  int   acc_cnt;
  bit   b_done;
  exp_t sb[$];

  argmax_8_16_if bus();

  argmax_8_16 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference: plain scan, first occurrence of the maximum.
  function automatic exp_t golden(input int v[8]);
    exp_t r;
    r.idx = 0;
    r.val = v[0];
    for (int i = 1; i < 8; i++) begin
      if (v[i] > r.val) begin
        r.idx = i;
        r.val = v[i];
      end
    end
    return r;
  endfunction

  // output_ready driver, changes just after each rising edge.
  initial begin
    bus.output_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1:       bus.output_ready = ($urandom_range(0, 1) == 1);
        2:       bus.output_ready = 1'b0;
        default: bus.output_ready = 1'b1;
      endcase
    end
  end

  // Output monitor: samples on the falling edge, values are stable until the next rising edge.
  initial begin
    logic  prev_vld;
    logic  prev_ordy;
    logic  prev_rst;
    idx_t  prev_idx;
    data_t prev_max;
    exp_t  e;
    prev_vld  = 1'b0;
    prev_ordy = 1'b0;
    prev_rst  = 1'b0;
    prev_idx  = '0;
    prev_max  = '0;
    forever begin
      @(negedge clk);
      if (reset && prev_rst && prev_vld && !prev_ordy) begin
        check("hold_vld", bus.output_valid, 1);
        check("hold_idx", bus.output_data, prev_idx);
        check("hold_max", bus.output_max, prev_max);
      end
      if (reset && bus.output_valid && bus.output_ready) begin
        if (sb.size() == 0) begin
          check("sb_unexpected", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("sb_idx", bus.output_data, e.idx);
          check("sb_max", bus.output_max, e.val);
          n_out++;
        end
      end
      prev_vld  = bus.output_valid;
      prev_ordy = bus.output_ready;
      prev_rst  = reset;
      prev_idx  = bus.output_data;
      prev_max  = bus.output_max;
    end
  end

  // Entered and left just after a rising edge.
  task automatic drive_elem(input int d, input bit rnd);
    int guard;
    bit ok;
    guard = 0;
    ok    = 1'b0;
    bus.input_data = data_t'(d);
    forever begin
      bus.input_valid = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
      ok = bus.input_valid && bus.input_ready;
      @(posedge clk);
      #1;
      bus.input_valid = 1'b0;
      if (ok) begin
        acc_cnt++;
        break;
      end
      guard++;
      if (guard > 1000) begin
        check("in_timeout", guard, 0);
        break;
      end
    end
  endtask

  task automatic send(input int v[8], input int n, input bit rnd, input bit push);
    if (push) sb.push_back(golden(v));
    for (int i = 0; i < n; i++) drive_elem(v[i], rnd);
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 400) begin
      @(posedge clk);
      k++;
    end
    #1;
    check(tag, sb.size(), 0);
  endtask

  // Hold a result pending while the next vector streams in, then release.
  task automatic stall_case(input int va[8], input int vb[8], input int hold, input string tag);
    exp_t eb;
    int   base;
    int   k;
    eb = golden(vb);
    rdy_mode = 2;
    send(va, 8, 1'b0, 1'b1);
    base   = acc_cnt;
    b_done = 1'b0;
    fork
      begin
        send(vb, 8, 1'b0, 1'b1);
        b_done = 1'b1;
      end
    join_none
    repeat (hold) @(posedge clk);
    @(negedge clk);
    check({tag, "_acc7"}, acc_cnt - base, 7);
    check({tag, "_irdy0"}, bus.input_ready, 0);
    check({tag, "_ovld"}, bus.output_valid, 1);
    rdy_mode = 0;
    @(posedge clk);
    @(negedge clk);
    // Output transfer and last-element load on the same edge.
    check({tag, "_sim_ordy"}, bus.output_ready, 1);
    check({tag, "_sim_irdy"}, bus.input_ready, 1);
    check({tag, "_sim_ivld"}, bus.input_valid, 1);
    @(negedge clk);
    check({tag, "_nb_vld"}, bus.output_valid, 1);
    check({tag, "_nb_idx"}, bus.output_data, eb.idx);
    check({tag, "_nb_max"}, bus.output_max, eb.val);
    k = 0;
    while (!b_done && k < 50) begin
      @(posedge clk);
      k++;
    end
    @(posedge clk);
    #1;
    check({tag, "_done"}, b_done, 1);
    wait_drain({tag, "_drain"});
  endtask

  initial begin
    int v1[8]  = '{3, -1, 7, 2, 7, 0, -5, 1};
    int v2[8]  = '{-8, -3, -3, -9, -100, -4, -32768, -7};
    int v3[8]  = '{0, 0, 0, 0, 0, 0, 0, 32767};
    int va[8]  = '{5, 5, 5, 5, 5, 5, 5, 5};
    int vb[8]  = '{-2, 9, -7, 9, 100, 3, -32768, 99};
    int vc[8]  = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32767};
    int vd[8]  = '{12, 40, -40, 39, 41, 41, 0, 2};
    int vp[8]  = '{1000, 2000, 3000, 4000, 5000, 6000, 7000, 8000};
    int vr[8]  = '{1, 2, 3, 4, 5, 6, 7, 8};
    int vx[8];
    int base;

    n_tests = 0;
    n_fail  = 0;
    n_out   = 0;
    acc_cnt = 0;
    b_done  = 1'b0;
    rdy_mode = 0;
    reset = 1'b0;
    bus.input_valid = 1'b0;
    bus.input_data  = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ovld", bus.output_valid, 0);
    check("rst_idx", bus.output_data, 0);
    check("rst_max", bus.output_max, 0);
    check("rst_irdy", bus.input_ready, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("rel_irdy", bus.input_ready, 1);
    @(posedge clk);
    #1;

    // Single vector, result visible right after the 8th transfer, then drops.
    send(v1, 8, 1'b0, 1'b1);
    check("t1_vld", bus.output_valid, 1);
    check("t1_idx", bus.output_data, 2);
    check("t1_max", bus.output_max, 7);
    @(posedge clk);
    #1;
    check("t1_vld_drop", bus.output_valid, 0);
    wait_drain("t1_drain");

    // All-negative vector and max at the last position.
    send(v2, 8, 1'b0, 1'b1);
    check("t2_idx", bus.output_data, 1);
    check("t2_max", bus.output_max, -3);
    send(v3, 8, 1'b0, 1'b1);
    check("t2b_idx", bus.output_data, 7);
    check("t2b_max", bus.output_max, 32767);
    wait_drain("t2_drain");

    // Pending result with output_ready low, then simultaneous transfer and load.
    stall_case(va, vb, 20, "t3");
    stall_case(vc, vd, 9, "t6");

    // Random traffic on both sides.
    base = n_out;
    rdy_mode = 1;
    for (int n = 0; n < 100; n++) begin
      for (int i = 0; i < 8; i++) begin
        if (n % 3 == 0) vx[i] = int'($urandom_range(0, 8)) - 4;
        else            vx[i] = int'($urandom_range(0, 65535)) - 32768;
      end
      send(vx, 8, 1'b1, 1'b1);
    end
    rdy_mode = 0;
    wait_drain("t4_drain");
    check("t4_count", n_out - base, 100);

    // Reset mid-vector discards the partial vector.
    base = n_out;
    send(vp, 5, 1'b0, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check("t5_rst_ovld", bus.output_valid, 0);
    check("t5_rst_irdy", bus.input_ready, 0);
    @(posedge clk);
    @(negedge clk);
    check("t5_rst_ovld2", bus.output_valid, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    send(vr, 8, 1'b0, 1'b1);
    check("t5_idx", bus.output_data, 7);
    check("t5_max", bus.output_max, 8);
    wait_drain("t5_drain");
    repeat (5) @(posedge clk);
    #1;
    check("t5_count", n_out - base, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
